sub_shift_rows_seq: RTL and testbench



---
 rtl/sub_shift_rows_seq.sv | 155 +++++++++++++++
 tb/tb_sub_shift_rows_seq.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sub_shift_rows_seq.sv
// Purpose : AES SubBytes + ShiftRows round stage, one output column per cycle via four shared S-boxes.
// Latency : block accepted at edge E0 is presented with out_valid=1 after edge E4; output and ready are state-decoded.
// Backpr. : result held stable in DONE until out_ready; in_ready=1 only in IDLE, or also in DONE tied to out_ready
//           when SUB_SHIFT_OVERLAP_EN is defined (output handshake and next capture share one edge).
// Ports   : clk, rst_n (async active-low); in_valid/in_ready/in_data[127:0] block input;
//           out_valid/out_ready/out_data[127:0] result, column c at [127-32c -: 32], row r at [127-32c-8r -: 8].
module sub_shift_rows_seq #(
  parameter int NK__KEY_LENGTH           = 8,
  parameter int NR__ROUNDS               = 14,
  parameter int NB__BLOCK_LENGTH_IN_TEXT = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  localparam int BW = NK__KEY_LENGTH;            // byte width
  localparam int NB = NB__BLOCK_LENGTH_IN_TEXT;  // columns per state
  localparam int CW = 4 * BW;                    // column width (four rows)

  // Only the AES defaults are meaningful for this datapath.
  if (NK__KEY_LENGTH != 8 || NB__BLOCK_LENGTH_IN_TEXT != 4 || NR__ROUNDS < 1) begin : g_param_check
    $error("sub_shift_rows_seq supports only 8-bit bytes and 4 columns");
  end

  // FIPS-197 forward S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [BW-1:0] sbox(input logic [BW-1:0] b);
    return SBOX_TBL[BW * (255 - int'(b)) +: BW];
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [1:0]      col;
  logic [CW-1:0]   in_col  [NB];
  logic [CW-1:0]   res_col [NB];
  logic [1:0]      src_col [4];
  logic [BW-1:0]   sb_in   [4];
  logic [BW-1:0]   sb_out  [4];
  logic            capture;

  // ---------------------------------------------------------------- state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = BUSY;
      BUSY: if (col == 2'd3) state_nxt = DONE;
      DONE: begin
        if (out_ready) begin
`ifdef SUB_SHIFT_OVERLAP_EN
          state_nxt = in_valid ? BUSY : IDLE;
`else
          state_nxt = IDLE;
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- outputs
  // Both handshake outputs are pure state decodes; with overlap, DONE
  // forwards out_ready so a new block only enters when the old one leaves.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: in_ready = 1'b1;
      DONE: begin
        out_valid = 1'b1;
`ifdef SUB_SHIFT_OVERLAP_EN
        in_ready  = out_ready;
`endif
      end
      default: ;
    endcase
  end

  assign capture = in_valid && in_ready;

  // ---------------------------------------------------------------- S-box lanes
  // Lane r produces row r of output column col, taken from input column
  // (col + r) mod 4; the 2-bit add gives the wrap for free.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      src_col[r] = col + 2'(r);
      sb_in[r]   = in_col[src_col[r]][CW-1-BW*r -: BW];
    end
  end

  for (genvar r = 0; r < 4; r++) begin : g_sbox
    assign sb_out[r] = sbox(sb_in[r]);
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= 2'd0;
      for (int c = 0; c < NB; c++) begin
        in_col[c]  <= '0;
        res_col[c] <= '0;
      end
    end else if (capture) begin
      col <= 2'd0;
      for (int c = 0; c < NB; c++) begin
        in_col[c] <= in_data[(NB-1-c)*CW +: CW];
      end
    end else if (state == BUSY) begin
      res_col[col] <= {sb_out[0], sb_out[1], sb_out[2], sb_out[3]};
      col          <= col + 2'd1;
    end
  end

  // Result register is not cleared on handshake; it shows the last block.
  assign out_data = {res_col[0], res_col[1], res_col[2], res_col[3]};

endmodule

// File: tb/tb_sub_shift_rows_seq.sv
// Bench for sub_shift_rows_seq: directed FIPS-197 vectors, backpressure, reset
// and back-to-back spacing, then randomized traffic against a reference model.
module tb_sub_shift_rows_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  int n_chk  = 0;
  int n_pass = 0;
  int acc_q[$];

  logic [7:0] sbox_tbl [256];

`ifdef SUB_SHIFT_OVERLAP_EN
  localparam int EXP_GAP = 5;
`else
  localparam int EXP_GAP = 6;
`endif

  localparam logic [127:0] APPB_IN  = 128'h193de3be_a0f4e22b_9ac68d2a_e9f84808;
  localparam logic [127:0] APPB_OUT = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;

  sub_shift_rows_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // S-box from its definition: multiplicative inverse then affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_tbl[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] ref_block(input logic [127:0] d);
    logic [127:0] o;
    int src;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        src = (c + r) % 4;
        o[8*(15-4*c-r) +: 8] = sbox_tbl[d[8*(15-4*src-r) +: 8]];
      end
    return o;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Accept one block with out_ready low and wait until it is presented.
  task automatic run_one(input logic [127:0] d, input logic [127:0] exp, input string tag);
    int n;
    logic rdy_seen;
    out_ready = 1'b0;
    in_data   = d;
    in_valid  = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
    chk({tag, "_accept_wait"}, 128'(n < 20), 128'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    rdy_seen = 1'b0;
    while (!out_valid && n < 20) begin
      rdy_seen = rdy_seen | in_ready;
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_latency"},   128'(n), 128'(4));
    chk({tag, "_busy_rdy"},  128'(rdy_seen), 128'(0));
    chk({tag, "_done_rdy"},  128'(in_ready), 128'(0));
    chk({tag, "_data"},      out_data, exp);
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_rel_valid"}, 128'(out_valid), 128'(0));
    chk({tag, "_rel_rdy"},   128'(in_ready),  128'(1));
  endtask

  task automatic run_stream(input int nblk, input int vld_pct, input int rdy_pct, input string tag);
    logic [127:0] exp_q[$];
    logic [127:0] exp;
    int sent, got, cyc;
    logic in_hs, out_hs;
    sent = 0; got = 0; cyc = 0;
    acc_q.delete();
    while (got < nblk && cyc < 40000) begin
      if (!in_valid && sent < nblk && int'($urandom_range(99)) < vld_pct) begin
        in_valid = 1'b1;
        in_data  = rand128();
      end
      out_ready = (int'($urandom_range(99)) < rdy_pct);
      @(negedge clk);
      in_hs  = in_valid && in_ready;
      out_hs = out_valid && out_ready;
      if (out_hs) begin
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        chk({tag, "_data"}, out_data, exp);
        got++;
      end
      if (in_hs) begin
        exp_q.push_back(ref_block(in_data));
        acc_q.push_back(cyc);
        sent++;
      end
      @(posedge clk); #1;
      if (in_hs) in_valid = 1'b0;
      cyc++;
    end
    out_ready = 1'b0;
    chk({tag, "_count"},   128'(got), 128'(nblk));
    chk({tag, "_leftover"}, 128'(exp_q.size()), 128'(0));
  endtask

  initial begin
    logic ok;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    build_sbox();

    #12;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_data",  out_data, 128'(0));
    chk("rst_in_ready",  128'(in_ready), 128'(1));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    run_one(APPB_IN, APPB_OUT, "appb");
    release_out("appb");
    run_one(128'(0), {16{8'h63}}, "zero");
    release_out("zero");
    run_one({128{1'b1}}, {16{8'h16}}, "ones");

    // Backpressure: held output, offered block must be ignored.
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = rand128();
      @(posedge clk); #1;
      ok = ok & out_valid & (out_data == {16{8'h16}}) & !in_ready;
    end
    chk("bp_hold", 128'(ok), 128'(1));
    in_valid = 1'b0;
    release_out("bp");
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      ok = ok & !out_valid;
    end
    chk("bp_no_capture", 128'(ok), 128'(1));

    // Reset while the third column is being computed.
    in_data  = APPB_IN;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy_valid", 128'(out_valid), 128'(0));
    chk("rst_busy_data",  out_data, 128'(0));
    chk("rst_busy_rdy",   128'(in_ready), 128'(1));
    @(negedge clk) rst_n = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      ok = ok & !out_valid & in_ready;
    end
    chk("rst_busy_discard", 128'(ok), 128'(1));
    run_one(APPB_IN, APPB_OUT, "appb_after_rst");
    release_out("appb_after_rst");

    // Reset while a result is being presented.
    run_one(128'(0), {16{8'h63}}, "zero2");
    #2 rst_n = 1'b0;
    #1;
    chk("rst_done_valid", 128'(out_valid), 128'(0));
    chk("rst_done_data",  out_data, 128'(0));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    run_one(APPB_IN, APPB_OUT, "appb_after_rst2");
    release_out("appb_after_rst2");

    // Back-to-back with in_valid held and out_ready high.
    run_stream(5, 100, 100, "b2b");
    for (int i = 1; i < acc_q.size(); i++)
      chk("b2b_gap", 128'(acc_q[i] - acc_q[i-1]), 128'(EXP_GAP));

    run_stream(1000, 60, 70, "rand");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
